// File: rtl/subsys_pkg.sv
// ----------------------------------------------------------------------------
// subsys_pkg
// Shared types and constants for the subsystem scheduler.
//   state_e      : scheduler FSM states
//   K_*          : key indices for quit/next/prev/select
//   LED_W, ROW_W : full frame width and matrix row width
// ----------------------------------------------------------------------------
package subsys_pkg;

    typedef enum logic [1:0] {
        MENU   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        DRAIN  = 2'd3
    } state_e;

    localparam int unsigned K_QUIT = 32'd0;
    localparam int unsigned K_NEXT = 32'd1;
    localparam int unsigned K_PREV = 32'd2;
    localparam int unsigned K_SEL  = 32'd4;

    localparam int unsigned LED_W  = 32'd256;
    localparam int unsigned ROW_W  = 32'd16;

endpackage : subsys_pkg

// File: rtl/subsys_sched_if.sv
// ----------------------------------------------------------------------------
// subsys_sched_if
// Bundle between the scheduler and its subsystems.
//   sub_led  : concatenated subsystem frames, subsystem i at [i*LED_W +: LED_W]
//   sub_back : per-subsystem return flag, 1 = done
//   en_sub_n : per-subsystem enable, active-low, at most one bit low
//   sub_keys : keys forwarded to the running subsystem, 0 otherwise
// Modports: master = scheduler side, slave = subsystem side.
// ----------------------------------------------------------------------------
interface subsys_sched_if #(
    parameter int NSUB  = 4,
    parameter int LED_W = 256,
    parameter int KEY_W = 9
);
    logic [NSUB*LED_W-1:0] sub_led;
    logic [NSUB-1:0]       sub_back;
    logic [NSUB-1:0]       en_sub_n;
    logic [KEY_W-1:0]      sub_keys;

    modport master (
        input  sub_led,
        input  sub_back,
        output en_sub_n,
        output sub_keys
    );

    modport slave (
        output sub_led,
        output sub_back,
        input  en_sub_n,
        input  sub_keys
    );
endinterface : subsys_sched_if

// File: rtl/subsys_sched_key_edge.sv
// ----------------------------------------------------------------------------
// key_edge
// Press detector: remembers last cycle's key levels and flags 0->1 edges.
//   clk      : system clock
//   rst      : synchronous reset, active-high (clears history)
//   keys_i   : synchronised key levels, 1 = pressed
//   press_o  : one-cycle pulse per newly pressed key
// ----------------------------------------------------------------------------
module key_edge #(
    parameter int KEY_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] keys_i,
    output logic [KEY_W-1:0] press_o
);
    logic [KEY_W-1:0] kprev_q;

    // Key history register
    always_ff @(posedge clk) begin
        if (rst) begin
            kprev_q <= '0;
        end else begin
            kprev_q <= keys_i;
        end
    end

    assign press_o = keys_i & ~kprev_q;

endmodule : key_edge

// File: rtl/subsys_sched.sv
// ----------------------------------------------------------------------------
// subsys_sched
// Shares the LED matrix and keys among NSUB subsystems: menu selection,
// launch with stale-return-flag guard, run-time routing, and reclaim on
// return flag or force-quit.
//   clk      : system clock
//   rst      : synchronous reset, active-high
//   keys     : synchronised key levels (key0 quit, key1 next, key2 prev, key4 select)
//   bus      : subsystem frames/flags in, enables/forwarded keys out
//   led      : registered frame to the matrix driver
//   sel      : menu selection / active subsystem index
//   busy     : 1 while a subsystem owns (or is handing back) the matrix
//   err      : sticky launch-timeout flag
// ----------------------------------------------------------------------------
module subsys_sched
    import subsys_pkg::*;
#(
    parameter int NSUB   = 4,
    parameter int LED_W  = 256,
    parameter int KEY_W  = 9,
    parameter int ACK_TO = 16,
    localparam int SEL_W = (NSUB > 1) ? $clog2(NSUB) : 1,
    localparam int CNT_W = (ACK_TO > 1) ? $clog2(ACK_TO) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [KEY_W-1:0]     keys,
    subsys_sched_if.master       bus,
    output logic [LED_W-1:0]     led,
    output logic [SEL_W-1:0]     sel,
    output logic                 busy,
    output logic                 err
);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NSUB - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TO - 1);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q,   sel_d;
    logic [NSUB-1:0]    en_q,    en_d;
    logic [LED_W-1:0]   led_q,   led_d;
    logic [KEY_W-1:0]   skeys_q, skeys_d;
    logic               err_q,   err_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [KEY_W-1:0]   press_s;
    logic               back_s;

    key_edge #(.KEY_W(KEY_W)) u_key_edge (
        .clk     (clk),
        .rst     (rst),
        .keys_i  (keys),
        .press_o (press_s)
    );

    // Only the selected subsystem's return flag is ever looked at
    assign back_s = bus.sub_back[sel_q];

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MENU;
            sel_q   <= '0;
            en_q    <= '1;
            led_q   <= '0;
            skeys_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            led_q   <= led_d;
            skeys_q <= skeys_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        en_d    = en_q;
        led_d   = '0;
        skeys_d = '0;
        err_d   = err_q;
        cnt_d   = cnt_q;

        case (state_q)
            MENU: begin
                led_d[sel_q*ROW_W +: ROW_W] = {ROW_W{1'b1}};
                en_d = '1;
                if (press_s[K_SEL]) begin
                    // Enable is built from all-ones so only one bit can ever be low
                    en_d        = '1;
                    en_d[sel_q] = 1'b0;
                    cnt_d       = '0;
                    state_d     = LAUNCH;
                end else if (press_s[K_NEXT] && !press_s[K_PREV]) begin
                    sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
                end else if (press_s[K_PREV] && !press_s[K_NEXT]) begin
                    sel_d = (sel_q == '0) ? SEL_LAST : sel_q - SEL_W'(1);
                end else begin
                    sel_d = sel_q;
                end
            end

            LAUNCH: begin
                // Wait for a stale return flag from the previous run to clear
                if (!back_s) begin
                    err_d   = 1'b0;
                    state_d = RUN;
                end else if (cnt_q == CNT_LAST) begin
                    en_d    = '1;
                    err_d   = 1'b1;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RUN: begin
                led_d   = bus.sub_led[sel_q*LED_W +: LED_W];
                skeys_d = keys;
                if (press_s[K_QUIT] || back_s) begin
                    en_d    = '1;
                    skeys_d = '0;
                    state_d = DRAIN;
                end else begin
                    state_d = RUN;
                end
            end

            DRAIN: begin
                // Hold here until every key is up so nothing leaks into the menu
                if (keys == '0) begin
                    state_d = MENU;
                end else begin
                    state_d = DRAIN;
                end
            end

            default: begin
                en_d    = '1;
                state_d = MENU;
            end
        endcase
    end

    assign led          = led_q;
    assign sel          = sel_q;
    assign err          = err_q;
    assign busy         = (state_q != MENU);
    assign bus.en_sub_n = en_q;
    assign bus.sub_keys = skeys_q;

endmodule : subsys_sched

// File: tb/tb_subsys_sched.sv
module tb_subsys_sched;
    localparam int NSUB   = 4;
    localparam int LED_W  = 256;
    localparam int KEY_W  = 9;
    localparam int ACK_TO = 16;

    logic              clk;
    logic              rst;
    logic [KEY_W-1:0]  keys;
    logic [LED_W-1:0]  led;
    logic [1:0]        sel;
    logic              busy;
    logic              err;

    int n_vec;
    int n_miss;

    subsys_sched_if #(.NSUB(NSUB), .LED_W(LED_W), .KEY_W(KEY_W)) bus ();

    subsys_sched #(.NSUB(NSUB), .LED_W(LED_W), .KEY_W(KEY_W), .ACK_TO(ACK_TO)) dut (
        .clk  (clk),
        .rst  (rst),
        .keys (keys),
        .bus  (bus),
        .led  (led),
        .sel  (sel),
        .busy (busy),
        .err  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [KEY_W-1:0] k);
        keys = k;
        step(1);
        keys = '0;
        step(1);
    endtask

    task automatic test_reset();
        logic [LED_W-1:0] exp;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        n_vec++; if (led !== 256'h0) begin n_miss++; $display("FAIL reset_led: got %h expected 0", led); end
        n_vec++; if (bus.en_sub_n !== 4'b1111) begin n_miss++; $display("FAIL reset_en: got %b expected 1111", bus.en_sub_n); end
        n_vec++; if ({sel, busy, err} !== 4'b0000) begin n_miss++; $display("FAIL reset_flags: got sel=%0d busy=%b err=%b expected 0 0 0", sel, busy, err); end
        n_vec++; if (bus.sub_keys !== 9'h000) begin n_miss++; $display("FAIL reset_keys: got %h expected 000", bus.sub_keys); end
        step(3);
        exp = 256'h0;
        exp[15:0] = 16'hFFFF;
        n_vec++; if (led !== exp) begin n_miss++; $display("FAIL menu_row0: got %h expected %h", led, exp); end
        n_vec++; if (busy !== 1'b0 || sel !== 2'd0) begin n_miss++; $display("FAIL menu_idle: got busy=%b sel=%0d expected 0 0", busy, sel); end
    endtask

    task automatic test_menu_nav();
        logic [LED_W-1:0] exp;
        press(9'b000000100);
        exp = 256'h0;
        exp[63:48] = 16'hFFFF;
        n_vec++; if (sel !== 2'd3) begin n_miss++; $display("FAIL prev_wrap: got sel=%0d expected 3", sel); end
        n_vec++; if (led !== exp) begin n_miss++; $display("FAIL row3: got %h expected %h", led, exp); end
        keys = 9'b000000010;
        step(3);
        n_vec++; if (sel !== 2'd0) begin n_miss++; $display("FAIL next_hold_wrap: got sel=%0d expected 0", sel); end
        keys = '0;
        step(1);
        press(9'b000000010);
        n_vec++; if (sel !== 2'd1) begin n_miss++; $display("FAIL next: got sel=%0d expected 1", sel); end
        press(9'b000000110);
        n_vec++; if (sel !== 2'd1) begin n_miss++; $display("FAIL next_prev_same: got sel=%0d expected 1", sel); end
    endtask

    task automatic test_launch_run();
        logic [LED_W-1:0] pat_a;
        logic [LED_W-1:0] pat_b;
        pat_a = {16{16'hA5C3}};
        pat_b = {16{16'h0F1E}};
        bus.sub_led = {{16{16'h3333}}, {16{16'h2222}}, {16{16'h1111}}, {16{16'h0001}}};
        bus.sub_back = 4'b0010;
        keys = 9'b000010000;
        step(1);
        keys = '0;
        n_vec++; if (bus.en_sub_n !== 4'b1101) begin n_miss++; $display("FAIL launch_en: got %b expected 1101", bus.en_sub_n); end
        step(3);
        n_vec++; if (busy !== 1'b1 || led !== 256'h0 || bus.en_sub_n !== 4'b1101) begin n_miss++; $display("FAIL launch_hold: got busy=%b en=%b led=%h expected 1 1101 0", busy, bus.en_sub_n, led); end
        bus.sub_back = 4'b0000;
        step(1);
        n_vec++; if (err !== 1'b0 || busy !== 1'b1) begin n_miss++; $display("FAIL run_entry: got err=%b busy=%b expected 0 1", err, busy); end
        bus.sub_led[511:256] = pat_a;
        keys = 9'b000001000;
        step(1);
        n_vec++; if (led !== pat_a) begin n_miss++; $display("FAIL run_frame_a: got %h expected %h", led, pat_a); end
        n_vec++; if (bus.sub_keys !== 9'b000001000) begin n_miss++; $display("FAIL run_keys: got %b expected 000001000", bus.sub_keys); end
        bus.sub_led[511:256] = pat_b;
        bus.sub_back = 4'b1101;
        step(1);
        n_vec++; if (led !== pat_b || bus.en_sub_n !== 4'b1101) begin n_miss++; $display("FAIL run_frame_b: got en=%b led=%h expected 1101 %h", bus.en_sub_n, led, pat_b); end
    endtask

    task automatic test_drain();
        logic [LED_W-1:0] exp;
        bus.sub_back = 4'b0010;
        step(1);
        n_vec++; if (bus.en_sub_n !== 4'b1111 || bus.sub_keys !== 9'h000) begin n_miss++; $display("FAIL return_exit: got en=%b keys=%h expected 1111 000", bus.en_sub_n, bus.sub_keys); end
        step(2);
        n_vec++; if (busy !== 1'b1 || led !== 256'h0) begin n_miss++; $display("FAIL drain_hold: got busy=%b led=%h expected 1 0", busy, led); end
        keys = '0;
        step(1);
        n_vec++; if (busy !== 1'b0 || sel !== 2'd1) begin n_miss++; $display("FAIL drain_exit: got busy=%b sel=%0d expected 0 1", busy, sel); end
        step(1);
        exp = 256'h0;
        exp[31:16] = 16'hFFFF;
        n_vec++; if (led !== exp) begin n_miss++; $display("FAIL menu_row1: got %h expected %h", led, exp); end
    endtask

    task automatic test_timeout();
        press(9'b000000010);
        n_vec++; if (sel !== 2'd2) begin n_miss++; $display("FAIL sel2: got sel=%0d expected 2", sel); end
        bus.sub_back = 4'b0100;
        keys = 9'b000010000;
        step(1);
        n_vec++; if (bus.en_sub_n !== 4'b1011) begin n_miss++; $display("FAIL to_launch_en: got %b expected 1011", bus.en_sub_n); end
        step(ACK_TO - 1);
        n_vec++; if (bus.en_sub_n !== 4'b1011 || err !== 1'b0) begin n_miss++; $display("FAIL to_last_cycle: got en=%b err=%b expected 1011 0", bus.en_sub_n, err); end
        step(1);
        n_vec++; if (bus.en_sub_n !== 4'b1111 || err !== 1'b1 || busy !== 1'b1) begin n_miss++; $display("FAIL to_expire: got en=%b err=%b busy=%b expected 1111 1 1", bus.en_sub_n, err, busy); end
        keys = '0;
        step(1);
        n_vec++; if (busy !== 1'b0 || err !== 1'b1) begin n_miss++; $display("FAIL to_menu: got busy=%b err=%b expected 0 1", busy, err); end
        bus.sub_back = 4'b0000;
        press(9'b000010000);
        n_vec++; if (err !== 1'b0 || bus.en_sub_n !== 4'b1011) begin n_miss++; $display("FAIL err_clear: got err=%b en=%b expected 0 1011", err, bus.en_sub_n); end
    endtask

    task automatic test_quit_and_rst();
        logic [LED_W-1:0] pat_c;
        pat_c = {16{16'h5AA5}};
        keys = 9'b000000001;
        bus.sub_back = 4'b0100;
        step(1);
        n_vec++; if (bus.en_sub_n !== 4'b1111 || busy !== 1'b1) begin n_miss++; $display("FAIL quit_exit: got en=%b busy=%b expected 1111 1", bus.en_sub_n, busy); end
        keys = '0;
        step(1);
        n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL quit_menu: got busy=%b expected 0", busy); end
        bus.sub_back = 4'b0000;
        press(9'b000010000);
        bus.sub_led[767:512] = pat_c;
        step(1);
        n_vec++; if (led !== pat_c || bus.en_sub_n !== 4'b1011) begin n_miss++; $display("FAIL run2_frame: got en=%b led=%h expected 1011 %h", bus.en_sub_n, led, pat_c); end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        n_vec++; if (bus.en_sub_n !== 4'b1111 || sel !== 2'd0 || led !== 256'h0 || busy !== 1'b0) begin n_miss++; $display("FAIL rst_run: got en=%b sel=%0d busy=%b led=%h expected 1111 0 0 0", bus.en_sub_n, sel, busy, led); end
    endtask

    initial begin
        n_vec = 0;
        n_miss = 0;
        rst = 1'b1;
        keys = '0;
        bus.sub_led = '0;
        bus.sub_back = '0;
        test_reset();
        test_menu_nav();
        test_launch_run();
        test_drain();
        test_timeout();
        test_quit_and_rst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule : tb_subsys_sched
